// File: rtl/alu_cmd_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Result entries gain a zero-flag bit when ALU_CMD_SEQ_ZERO_EN is defined.
package alu_cmd_seq_pkg;

  localparam int ALU_LATENCY = 2;
  localparam int DATA_W      = 8;

`ifdef ALU_CMD_SEQ_ZERO_EN
  localparam int RES_W = DATA_W + 1;
`else
  localparam int RES_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [3:0] sel;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored.
// Depth need not be a power of two: pointers wrap explicitly at DEPTH-1.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// Sequences commands into a two-stage registered ALU with credit-based result buffering and flush.
// Optional OUT_ZERO output is enabled by defining ALU_CMD_SEQ_ZERO_EN.
module alu_cmd_seq
  import alu_cmd_seq_pkg::*;
#(
  parameter int CDEPTH = 4,
  parameter int RDEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] IN_A,
  input  logic [7:0] IN_B,
  input  logic       IN_CIN,
  input  logic [3:0] IN_SEL,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic       ALU_CIN,
  output logic [3:0] ALU_SEL,
  output logic       ALU_RST_N,
  input  logic [7:0] ALU_Y,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] OUT_Y,
`ifdef ALU_CMD_SEQ_ZERO_EN
  output logic       OUT_ZERO,
`endif
  input  logic       FLUSH,
  output logic       FLUSH_DONE
);

  localparam int CCW = $clog2(CDEPTH) + 1;
  localparam int RCW = $clog2(RDEPTH) + 1;
  localparam int IFW = $clog2(ALU_LATENCY + 1);

  state_t                 state_reg;
  logic                   flush_done_reg;
  logic                   ready_en_reg;
  logic [3:0]             sel_reg;
  logic [ALU_LATENCY-1:0] pipe_vld_reg;

  cmd_t             cmd_in;
  cmd_t             cmd_head;
  logic             cmd_full;
  logic             cmd_empty;
  logic [CCW-1:0]   cmd_count;
  logic             accept;
  logic             issue;

  logic [RES_W-1:0] res_in;
  logic [RES_W-1:0] res_head;
  logic             res_push;
  logic             res_full;
  logic             res_empty;
  logic [RCW-1:0]   res_count;

  logic [IFW-1:0]   inflight;
  logic [RCW:0]     committed;
  logic             unused_status;

  assign ALU_RST_N = ~RST;

  // ready_en_reg holds IN_READY low until the first edge after reset release
  assign IN_READY = ready_en_reg & (state_reg == RUN) & ~cmd_full;
  assign accept   = IN_VALID & IN_READY;
  assign cmd_in   = '{a: IN_A, b: IN_B, cin: IN_CIN, sel: IN_SEL};

  sync_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(CDEPTH)
  ) u_cmd_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (accept),
    .push_data(cmd_in),
    .pop      (issue),
    .pop_data (cmd_head),
    .full     (cmd_full),
    .empty    (cmd_empty),
    .count    (cmd_count)
  );

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ALU_LATENCY; i++) inflight = inflight + IFW'(pipe_vld_reg[i]);
  end

  // Every issued op already owns a result slot, so the result FIFO can never overflow
  assign committed = (RCW + 1)'(res_count) + (RCW + 1)'(inflight);
  assign issue     = ~cmd_empty & (committed < (RCW + 1)'(RDEPTH));

  assign ALU_A   = issue ? cmd_head.a   : '0;
  assign ALU_B   = issue ? cmd_head.b   : '0;
  assign ALU_CIN = issue ? cmd_head.cin : 1'b0;
  assign ALU_SEL = sel_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_reg      <= '0;
      pipe_vld_reg <= '0;
    end else begin
      sel_reg      <= issue ? cmd_head.sel : 4'd0;
      pipe_vld_reg <= {pipe_vld_reg[ALU_LATENCY-2:0], issue};
    end
  end

  assign res_push = pipe_vld_reg[ALU_LATENCY-1];
`ifdef ALU_CMD_SEQ_ZERO_EN
  assign res_in   = {(ALU_Y == 8'd0), ALU_Y};
  assign OUT_ZERO = OUT_VALID & res_head[DATA_W];
`else
  assign res_in   = ALU_Y;
`endif

  sync_fifo #(
    .WIDTH(RES_W),
    .DEPTH(RDEPTH)
  ) u_res_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (res_push),
    .push_data(res_in),
    .pop      (OUT_VALID & OUT_READY),
    .pop_data (res_head),
    .full     (res_full),
    .empty    (res_empty),
    .count    (res_count)
  );

  assign OUT_VALID     = ~res_empty;
  assign OUT_Y         = res_empty ? 8'd0 : res_head[DATA_W-1:0];
  assign FLUSH_DONE    = flush_done_reg;
  assign unused_status = res_full ^ (^cmd_count);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= RUN;
      flush_done_reg <= 1'b0;
      ready_en_reg   <= 1'b0;
    end else begin
      ready_en_reg   <= 1'b1;
      flush_done_reg <= 1'b0;
      case (state_reg)
        RUN:   if (FLUSH) state_reg <= DRAIN;
        DRAIN: begin
          if (cmd_empty && (inflight == '0) && res_empty) begin
            state_reg      <= DONE;
            flush_done_reg <= 1'b1;
          end
        end
        DONE:  if (!FLUSH) state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Randomized bench for alu_cmd_seq: a registered ALU model plus a queue of expected results.
`timescale 1ns/1ps
module tb_alu_cmd_seq;

  localparam int CDEPTH = 4;
  localparam int RDEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] IN_A = '0;
  logic [7:0] IN_B = '0;
  logic       IN_CIN = 1'b0;
  logic [3:0] IN_SEL = '0;
  logic [7:0] ALU_A;
  logic [7:0] ALU_B;
  logic       ALU_CIN;
  logic [3:0] ALU_SEL;
  logic       ALU_RST_N;
  logic [7:0] ALU_Y;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] OUT_Y;
`ifdef ALU_CMD_SEQ_ZERO_EN
  logic       OUT_ZERO;
`endif
  logic       FLUSH = 1'b0;
  logic       FLUSH_DONE;

  always #5 CLK = ~CLK;

  alu_cmd_seq #(
    .CDEPTH(CDEPTH),
    .RDEPTH(RDEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_A      (IN_A),
    .IN_B      (IN_B),
    .IN_CIN    (IN_CIN),
    .IN_SEL    (IN_SEL),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ALU_CIN   (ALU_CIN),
    .ALU_SEL   (ALU_SEL),
    .ALU_RST_N (ALU_RST_N),
    .ALU_Y     (ALU_Y),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_Y     (OUT_Y),
`ifdef ALU_CMD_SEQ_ZERO_EN
    .OUT_ZERO  (OUT_ZERO),
`endif
    .FLUSH     (FLUSH),
    .FLUSH_DONE(FLUSH_DONE)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Function applied by the downstream ALU; sel 0111 is add-with-carry, 1110 is xor
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic [3:0] sel);
    case (sel)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a - b;
      4'd3:    return ~a;
      4'd4:    return a + b;
      4'd5:    return a + 8'd1;
      4'd6:    return {a[6:0], cin};
      4'd7:    return a + b + {7'd0, cin};
      4'd14:   return a ^ b;
      default: return {a[3:0], b[7:4]} ^ {sel, sel};
    endcase
  endfunction

  // ALU model: operands registered at issue, SEL applied one cycle later, result registered
  logic [7:0] alu_a_r, alu_b_r, alu_y_r;
  logic       alu_cin_r;
  always @(posedge CLK) begin
    alu_a_r   <= ALU_A;
    alu_b_r   <= ALU_B;
    alu_cin_r <= ALU_CIN;
    alu_y_r   <= alu_fn(alu_a_r, alu_b_r, alu_cin_r, ALU_SEL);
  end
  assign ALU_Y = alu_y_r;

  logic [7:0] exp_q[$];
  int cyc = 0;
  int out_cnt = 0;
  int first_out = -1;
  int last_out = -1;
  int fd_cnt = 0;

  always @(negedge CLK) begin
    logic [7:0] e;
    cyc++;
    if (!RST) begin
      if (FLUSH_DONE) fd_cnt++;
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(OUT_VALID), 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_y", 32'(OUT_Y), 32'(e));
`ifdef ALU_CMD_SEQ_ZERO_EN
          chk("out_zero", 32'(OUT_ZERO), 32'(e == 8'd0));
`endif
          out_cnt++;
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
          $display("result %0d: y=%02h expected=%02h", out_cnt, OUT_Y, e);
        end
      end
      if (IN_VALID && IN_READY) exp_q.push_back(alu_fn(IN_A, IN_B, IN_CIN, IN_SEL));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_rand();
    IN_A   = 8'($urandom);
    IN_B   = ($urandom_range(0, 7) == 0) ? IN_A : 8'($urandom);
    IN_CIN = 1'($urandom);
    IN_SEL = 4'($urandom);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || OUT_VALID) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(exp_q.size()) + 32'(OUT_VALID), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepted;
    int sent;
    int n;
    logic [7:0] bp_a[10];

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", 32'(IN_READY), 0);
    chk("rst_out_valid", 32'(OUT_VALID), 0);
    chk("rst_out_y", 32'(OUT_Y), 0);
    chk("rst_flush_done", 32'(FLUSH_DONE), 0);
    chk("rst_alu_sel", 32'(ALU_SEL), 0);
    chk("rst_alu_rst_n", 32'(ALU_RST_N), 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ready_before_edge", 32'(IN_READY), 0);
    chk("alu_rst_n_release", 32'(ALU_RST_N), 1);
    step();
    chk("ready_after_edge", 32'(IN_READY), 1);

    // single op timing
    OUT_READY = 1'b1;
    IN_VALID = 1'b1; IN_A = 8'h05; IN_B = 8'h03; IN_CIN = 1'b1; IN_SEL = 4'b0111;
    step();
    IN_VALID = 1'b0;
    chk("t0_alu_a", 32'(ALU_A), 32'h05);
    chk("t0_alu_b", 32'(ALU_B), 32'h03);
    chk("t0_alu_cin", 32'(ALU_CIN), 1);
    step();
    chk("t1_alu_sel", 32'(ALU_SEL), 32'b0111);
    chk("t1_alu_a_idle", 32'(ALU_A), 0);
    step();
    chk("t2_out_valid", 32'(OUT_VALID), 0);
    step();
    chk("t3_out_valid", 32'(OUT_VALID), 1);
    chk("t3_out_y", 32'(OUT_Y), 32'h09);
    step();

    // 16 back-to-back ops at full throughput
    out_cnt = 0; first_out = -1; last_out = -1;
    for (int i = 0; i < 16; i++) begin
      IN_VALID = 1'b1;
      drive_rand();
      chk("b2b_in_ready", 32'(IN_READY), 1);
      step();
    end
    IN_VALID = 1'b0;
    wait_drain("b2b_drain", 60);
    chk("b2b_count", 32'(out_cnt), 16);
    chk("b2b_span", 32'(last_out - first_out + 1), 16);

    // backpressure: 10 ops with OUT_READY low
    OUT_READY = 1'b0; out_cnt = 0; accepted = 0;
    for (int i = 0; i < 10; i++) bp_a[i] = 8'($urandom);
    for (int c = 0; c < 20; c++) begin
      IN_VALID = (accepted < 10);
      IN_A = bp_a[accepted % 10]; IN_B = 8'(accepted); IN_CIN = 1'b0; IN_SEL = 4'd4;
      if (IN_VALID && IN_READY) accepted++;
      step();
    end
    IN_VALID = 1'b0;
    chk("bp_accepted", 32'(accepted), RDEPTH + CDEPTH);
    chk("bp_in_ready", 32'(IN_READY), 0);
    chk("bp_out_valid", 32'(OUT_VALID), 1);
    chk("bp_nothing_out", 32'(out_cnt), 0);
    OUT_READY = 1'b1;
    n = 0;
    while (accepted < 10 && n < 40) begin
      IN_VALID = 1'b1;
      IN_A = bp_a[accepted]; IN_B = 8'(accepted); IN_CIN = 1'b0; IN_SEL = 4'd4;
      if (IN_READY) accepted++;
      step();
      n++;
    end
    IN_VALID = 1'b0;
    wait_drain("bp_drain", 60);
    chk("bp_total", 32'(out_cnt), 10);

    // flush with 3 ops queued, FLUSH dropped mid-drain
    OUT_READY = 1'b0; out_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1;
      drive_rand();
      chk("fl_fill_ready", 32'(IN_READY), 1);
      step();
    end
    IN_VALID = 1'b0; FLUSH = 1'b1;
    step();
    chk("fl_in_ready", 32'(IN_READY), 0);
    step();
    FLUSH = 1'b0;
    repeat (3) step();
    chk("fl_hold_ready", 32'(IN_READY), 0);
    chk("fl_no_early_done", 32'(fd_cnt), 0);
    OUT_READY = 1'b1;
    n = 0;
    while (!FLUSH_DONE && n < 30) begin
      step();
      n++;
    end
    chk("fl_done_seen", 32'(FLUSH_DONE), 1);
    chk("fl_drained", 32'(out_cnt), 3);
    chk("fl_queue_empty", 32'(exp_q.size()), 0);
    chk("fl_done_not_ready", 32'(IN_READY), 0);
    step();
    chk("fl_done_pulse", 32'(FLUSH_DONE), 0);
    chk("fl_run_ready", 32'(IN_READY), 1);
    repeat (3) step();
    chk("fl_pulse_count", 32'(fd_cnt), 1);

    // flush held high through DONE
    fd_cnt = 0; FLUSH = 1'b1;
    repeat (7) step();
    chk("flh_pulses", 32'(fd_cnt), 1);
    chk("flh_ready", 32'(IN_READY), 0);
    FLUSH = 1'b0;
    step();
    chk("flh_resume", 32'(IN_READY), 1);

    // reset with two ops in flight
    OUT_READY = 1'b1; out_cnt = 0;
    IN_VALID = 1'b1; drive_rand();
    step();
    drive_rand();
    step();
    IN_VALID = 1'b0;
    step();
    RST = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(OUT_VALID), 0);
    chk("rst_mid_in_ready", 32'(IN_READY), 0);
    exp_q.delete();
    repeat (2) step();
    @(negedge CLK);
    RST = 1'b0;
    repeat (12) step();
    chk("rst_no_stale", 32'(out_cnt), 0);
    chk("rst_out_valid_after", 32'(OUT_VALID), 0);

    // xor of equal operands gives a zero result
    out_cnt = 0;
    IN_VALID = 1'b1; IN_A = 8'h5A; IN_B = 8'h5A; IN_CIN = 1'b0; IN_SEL = 4'b1110;
    step();
    IN_VALID = 1'b0;
    wait_drain("zero_drain", 20);
    chk("zero_count", 32'(out_cnt), 1);

    // random traffic with random backpressure
    out_cnt = 0; sent = 0;
    for (int c = 0; c < 400; c++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      drive_rand();
      if (IN_VALID && IN_READY) sent++;
      step();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    wait_drain("rnd_drain", 100);
    chk("rnd_count", 32'(out_cnt), 32'(sent));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameter CDEPTH, default 4: command FIFO depth; power of 2, 2..16.
REQ-002 SHALL have parameter RDEPTH, default 4: result FIFO depth; 3..16.
REQ-003 SHALL have port CLK  in  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port RST  in  1  reset; one clock, reset asynchronous, active-high.
REQ-005 SHALL have ports IN_VALID in 1 / IN_READY out 1: command handshake.
REQ-006 SHALL have ports IN_A in 8, IN_B in 8, IN_CIN in 1, IN_SEL in 4: command operands/opcode.
REQ-007 SHALL have ports ALU_A out 8, ALU_B out 8, ALU_CIN out 1, ALU_SEL out 4: drive the downstream ALU.
REQ-008 SHALL have port ALU_RST_N out 1 = ~RST, combinational.
REQ-009 SHALL have port ALU_Y in 8: registered ALU result.
REQ-010 SHALL have ports OUT_VALID out 1 / OUT_READY in 1 / OUT_Y out 8: result handshake.
REQ-011 SHALL have ports FLUSH in 1 (level request) and FLUSH_DONE out 1 (one-cycle pulse).

Function
REQ-012 Command accepted when IN_VALID & IN_READY; IN_READY = state RUN & command FIFO not full.
REQ-013 Issue in cycle t when FIFO non-empty and credit available: pop head, drive its A/B/CIN on ALU_A/B/CIN in cycle t; ALU_A/B/CIN = 0 otherwise.
REQ-014 ALU_SEL SHALL be the issued SEL delayed one cycle (driven in cycle t+1), since the ALU registers A/B/CIN but applies SEL after its input register.
REQ-015 ALU_Y sampled in cycle t+2 and pushed into result FIFO; a 2-bit valid shift register tracks in-flight ops.
REQ-016 Credit: issue only if (result FIFO occupancy + in-flight count) < RDEPTH; result FIFO never overflows, ALU_Y never dropped.
REQ-017 Back-to-back issue every cycle SHALL be supported; throughput 1 op/cycle when OUT_READY held high.
REQ-018 OUT_VALID = result FIFO non-empty; OUT_Y = head; pop on OUT_VALID & OUT_READY; results in issue order.
REQ-019 Simultaneous push and pop on either FIFO SHALL be allowed when full (command: pop frees, push accepted only if not full at cycle start) and when empty (no pass-through; push visible next cycle).
REQ-020 Pointers SHALL wrap modulo depth; occupancy counters width clog2(depth)+1.
REQ-021 FSM states: RUN, DRAIN, DONE. RUN->DRAIN when FLUSH=1. DRAIN: no accepts, issue continues; DRAIN->DONE when command FIFO empty, in-flight 0, result FIFO empty. DONE: FLUSH_DONE=1 for that cycle; DONE->RUN next cycle if FLUSH=0, else stay in DONE with FLUSH_DONE=0.
REQ-022 FLUSH deasserted during DRAIN SHALL NOT abort drain.

Reset
REQ-023 On RST: FIFOs empty, pointers 0, in-flight 0, state RUN, ALU_SEL 0, IN_READY 0 while RST=1, OUT_VALID 0, OUT_Y 0, FLUSH_DONE 0.
REQ-024 Reset mid-operation SHALL discard all queued and in-flight ops; no result emitted for them after release.
REQ-025 IN_READY SHALL rise no earlier than the first edge after RST deasserts.

Configuration
REQ-026 Macro ALU_CMD_SEQ_ZERO_EN: when defined, adds port OUT_ZERO out 1 = (OUT_Y==0) & OUT_VALID, carried in result FIFO as a 9th bit; when undefined, port and bit absent, behaviour otherwise identical.

Structure
REQ-027 Package alu_cmd_seq_pkg SHALL hold the FSM state enum, the command struct (a, b, cin, sel) and ALU_LATENCY=2.
REQ-028 One sub-module sync_fifo (parameterised width/depth, full/empty/count) SHALL be instantiated twice.

Verification
REQ-029 Single op A=0x05 B=0x03 CIN=1 SEL=0111 -> ALU_A=05 cycle t, ALU_SEL=0111 at t+1, OUT_Y=0x09 OUT_VALID at t+3.
REQ-030 16 back-to-back ops, OUT_READY=1 -> 16 results in order, one per cycle, no IN_READY drop after first.
REQ-031 OUT_READY=0, push 10 ops -> exactly RDEPTH results buffered, CDEPTH accepted, IN_READY=0 after; release -> all 10 emerge in order.
REQ-032 FLUSH with 3 ops queued -> IN_READY=0, 3 results drained, single FLUSH_DONE pulse, RUN resumes.
REQ-033 RST asserted with 2 in flight -> OUT_VALID=0, zero stale results after release; with ZERO_EN, op SEL=1110 A=B=0x5A -> OUT_ZERO=1.
